// File: rtl/maxnet_pkg.sv
// Shared definitions for the Maxnet pattern/weight memory arbiter.
package maxnet_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_t;

  typedef logic req_id_t;

endpackage

// File: rtl/maxnet_mem_arbiter_if.sv
// Requester and memory bus of the Maxnet arbiter; slave = arbiter side.
interface maxnet_mem_arbiter_if
  import maxnet_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);

  logic              r0_req, r0_lock, r0_we, r0_gnt, r0_rvalid;
  logic [ADDR_W-1:0] r0_addr;
  logic [DATA_W-1:0] r0_wdata, r0_rdata;
  logic              r1_req, r1_lock, r1_we, r1_gnt, r1_rvalid;
  logic [ADDR_W-1:0] r1_addr;
  logic [DATA_W-1:0] r1_wdata, r1_rdata;
  logic              mem_re, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic              busy;

  modport slave (
    input  r0_req, r0_lock, r0_we, r0_addr, r0_wdata,
    input  r1_req, r1_lock, r1_we, r1_addr, r1_wdata,
    input  mem_rdata,
    output r0_gnt, r0_rvalid, r0_rdata,
    output r1_gnt, r1_rvalid, r1_rdata,
    output mem_re, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output r0_req, r0_lock, r0_we, r0_addr, r0_wdata,
    output r1_req, r1_lock, r1_we, r1_addr, r1_wdata,
    output mem_rdata,
    input  r0_gnt, r0_rvalid, r0_rdata,
    input  r1_gnt, r1_rvalid, r1_rdata,
    input  mem_re, mem_we, mem_addr, mem_wdata, busy
  );

endinterface

// File: rtl/arb_burst_cnt.sv
// Saturating count of consecutive locked beats; at_cap means the burst must end.
module arb_burst_cnt #(
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic at_cap
);

  localparam logic [CNT_W-1:0] CAP = CNT_W'(MAX_BURST - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != CAP)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign at_cap = (cnt == CAP);

endmodule

// File: rtl/maxnet_mem_arbiter.sv
// Round-robin arbiter between the Maxnet sequencer (r0) and host loader (r1)
// for the 8-entry pattern/weight memory, with capped locked bursts.
//
// state | meaning
// IDLE  | no owner, no beat; picks next owner from requests and ptr
// GNT0  | sequencer owns the memory; one beat per cycle while r0_req
// GNT1  | host loader owns the memory; one beat per cycle while r1_req
module maxnet_mem_arbiter
  import maxnet_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int MAX_BURST = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  maxnet_mem_arbiter_if.slave bus
);

  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  arb_state_t        state;
  req_id_t           ptr, own, tag_own;
  logic              tag_vld;
  logic              g0, g1, mem_re_c, at_cap, cnt_inc, cnt_clr;
  logic              own_req, own_lock, oth_req, keep;
  logic [ADDR_W-1:0] addr_sel;
  logic [DATA_W-1:0] wdata_sel;
  logic              rv0, rv1;

  always_comb begin
    g0       = (state == GNT0) && bus.r0_req;
    g1       = (state == GNT1) && bus.r1_req;
    own      = req_id_t'(state == GNT1);
    own_req  = own ? bus.r1_req  : bus.r0_req;
    own_lock = own ? bus.r1_lock : bus.r0_lock;
    oth_req  = own ? bus.r0_req  : bus.r1_req;
    keep     = own_req && own_lock && !at_cap;
    // Any cycle that does not extend a locked burst restarts the count.
    cnt_inc  = (state != IDLE) && keep;
    cnt_clr  = !cnt_inc;
    mem_re_c = (g0 && !bus.r0_we) || (g1 && !bus.r1_we);
    addr_sel  = g0 ? bus.r0_addr  : (g1 ? bus.r1_addr  : '0);
    wdata_sel = g0 ? bus.r0_wdata : (g1 ? bus.r1_wdata : '0);
  end

  arb_burst_cnt #(
    .MAX_BURST (MAX_BURST),
    .CNT_W     (CNT_W)
  ) u_burst_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (cnt_clr),
    .inc    (cnt_inc),
    .at_cap (at_cap)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= 1'b0;
      tag_vld <= 1'b0;
      tag_own <= 1'b0;
    end else begin
      tag_vld <= mem_re_c;
      tag_own <= g1;
      case (state)
        IDLE: begin
          if (bus.r0_req && bus.r1_req) state <= ptr ? GNT1 : GNT0;
          else if (bus.r0_req)          state <= GNT0;
          else if (bus.r1_req)          state <= GNT1;
        end
        GNT0, GNT1: begin
          if (keep) begin
            state <= state;
          end else if (oth_req) begin
            state <= own ? GNT0 : GNT1;
            ptr   <= own;
          end else if (!own_req) begin
            state <= IDLE;
            ptr   <= !own;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rv0 = tag_vld && !tag_own;
  assign rv1 = tag_vld && tag_own;

  assign bus.r0_gnt    = g0;
  assign bus.r1_gnt    = g1;
  assign bus.r0_rvalid = rv0;
  assign bus.r1_rvalid = rv1;
  assign bus.r0_rdata  = rv0 ? bus.mem_rdata : '0;
  assign bus.r1_rdata  = rv1 ? bus.mem_rdata : '0;
  assign bus.mem_re    = mem_re_c;
  assign bus.mem_we    = (g0 && bus.r0_we) || (g1 && bus.r1_we);
  assign bus.mem_addr  = addr_sel;
  assign bus.mem_wdata = wdata_sel;
  assign bus.busy      = (state != IDLE);

endmodule
